smi_req_type_router: RTL



---
 rtl/smi_req_type_router.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/smi_req_type_router.sv
// Routes SMI request frames to the read or write adaptor by header type byte; unknown frames are dropped.
// Latency: 2 cycles from input acceptance to output Ready; 1 flit/cycle sustained, no bubble between frames.
// Backpressure: smiInStop follows only the selected port's Stop. SMI_ROUTER_DROP_COUNT_EN adds a saturating dropCount.
module smi_req_type_router #(
    parameter int         DataIndexSize = 4,
    parameter logic [7:0] ReadReqId     = 8'h02,
    parameter logic [7:0] WriteReqId    = 8'h01,
    localparam int        DataWidth     = (1 << DataIndexSize) * 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 smiInReady,
    input  logic [7:0]           smiInEofc,
    input  logic [DataWidth-1:0] smiInData,
    output logic                 smiInStop,
    output logic                 smiRdReady,
    output logic [7:0]           smiRdEofc,
    output logic [DataWidth-1:0] smiRdData,
    input  logic                 smiRdStop,
    output logic                 smiWrReady,
    output logic [7:0]           smiWrEofc,
    output logic [DataWidth-1:0] smiWrData,
    input  logic                 smiWrStop,
    output logic                 dropPulse
`ifdef SMI_ROUTER_DROP_COUNT_EN
    ,
    output logic [15:0]          dropCount
`endif
);

    typedef struct packed {
        logic [7:0]           eofc;
        logic [DataWidth-1:0] data;
    } flit_t;

    localparam logic [1:0] Idle    = 2'd0;
    localparam logic [1:0] RouteRd = 2'd1;
    localparam logic [1:0] RouteWr = 2'd2;
    localparam logic [1:0] Discard = 2'd3;

    logic [1:0] state, nextState;
    logic       inReady_q, rdReady_q, wrReady_q;
    flit_t      inFlit_q, rdFlit_q, wrFlit_q;
    logic       inHalt, inFire, rdHalt, wrHalt;
    logic       selRd, selWr, isRd, isWr, lastFlit;

    assign isRd     = inFlit_q.data[7:0] == ReadReqId;
    assign isWr     = inFlit_q.data[7:0] == WriteReqId;
    assign lastFlit = inFlit_q.eofc != 8'd0;

    assign rdHalt    = rdReady_q & smiRdStop;
    assign wrHalt    = wrReady_q & smiWrStop;
    assign smiInStop = inReady_q & inHalt;
    assign inFire    = inReady_q & ~inHalt;

    // Port selection depends only on state and the held flit, never on Stop.
    always_comb begin
        selRd = 1'b0;
        selWr = 1'b0;
        case (state)
            Idle: begin
                selRd = isRd;
                selWr = isWr;
            end
            RouteRd: selRd = 1'b1;
            RouteWr: selWr = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        inHalt = 1'b0;
        if (selRd) begin
            inHalt = rdHalt;
        end else if (selWr) begin
            inHalt = wrHalt;
        end
    end

    always_comb begin
        nextState = state;
        if (inFire) begin
            if (state == Idle) begin
                if (!lastFlit) begin
                    nextState = isRd ? RouteRd : (isWr ? RouteWr : Discard);
                end
            end else if (lastFlit) begin
                nextState = Idle;
            end
        end
    end

    assign dropPulse = inFire & (state == Idle) & ~isRd & ~isWr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= Idle;
            inReady_q <= 1'b0;
            rdReady_q <= 1'b0;
            wrReady_q <= 1'b0;
        end else begin
            state <= nextState;
            if (!smiInStop) begin
                inReady_q <= smiInReady;
            end
            // An unselected port still drains whatever it already holds.
            if (!rdHalt) begin
                rdReady_q <= inReady_q & selRd;
            end
            if (!wrHalt) begin
                wrReady_q <= inReady_q & selWr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!smiInStop && smiInReady) begin
            inFlit_q <= '{eofc: smiInEofc, data: smiInData};
        end
        if (!rdHalt && inReady_q && selRd) begin
            rdFlit_q <= inFlit_q;
        end
        if (!wrHalt && inReady_q && selWr) begin
            wrFlit_q <= inFlit_q;
        end
    end

    assign smiRdReady = rdReady_q;
    assign smiRdEofc  = rdFlit_q.eofc;
    assign smiRdData  = rdFlit_q.data;
    assign smiWrReady = wrReady_q;
    assign smiWrEofc  = wrFlit_q.eofc;
    assign smiWrData  = wrFlit_q.data;

`ifdef SMI_ROUTER_DROP_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dropCount <= 16'd0;
        end else if (dropPulse && dropCount != 16'hFFFF) begin
            dropCount <= dropCount + 16'd1;
        end
    end
`endif

endmodule
